// File: rtl/nx_ram_1rw_hw_client_if.sv
`default_nettype none
// ============================================================================
// Module   : nx_ram_1rw_hw_client_if
// Brief    : Request/response and wrapper-port bundle for the 1RW RAM
//            hardware client.
// Revision : 1.0 - initial release
// ============================================================================
interface nx_ram_1rw_hw_client_if #(
    parameter int N_DATA_BITS = 38,
    parameter int N_ADDR_BITS = 14
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [N_ADDR_BITS-1:0] req_addr;
    logic [N_DATA_BITS-1:0] req_wdat;
    logic [N_DATA_BITS-1:0] req_bwe;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [N_DATA_BITS-1:0] rsp_dat;

    logic                   hw_cs;
    logic                   hw_we;
    logic [N_ADDR_BITS-1:0] hw_add;
    logic [N_DATA_BITS-1:0] hw_bwe;
    logic [N_DATA_BITS-1:0] hw_din;
    logic [N_DATA_BITS-1:0] hw_dout;
    logic                   hw_yield;

    logic                   addr_err;

    // Master is the environment: requester, response consumer and RAM wrapper.
    modport master (
        output req_valid, req_we, req_addr, req_wdat, req_bwe,
        output rsp_ready,
        output hw_dout, hw_yield,
        input  req_ready, rsp_valid, rsp_dat,
        input  hw_cs, hw_we, hw_add, hw_bwe, hw_din,
        input  addr_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdat, req_bwe,
        input  rsp_ready,
        input  hw_dout, hw_yield,
        output req_ready, rsp_valid, rsp_dat,
        output hw_cs, hw_we, hw_add, hw_bwe, hw_din,
        output addr_err
    );
endinterface
`default_nettype wire

// File: rtl/nx_ram_1rw_hw_client.sv
`default_nettype none
// ============================================================================
// Module   : nx_ram_1rw_hw_client
// Brief    : Hardware request front-end for the 1RW indirect-access RAM
//            wrapper; credit-gated reads feed an in-order response FIFO.
// Options  : define NX_HW_CLIENT_ADDR_CHECK_EN to trap addresses > ADDR_LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module nx_ram_1rw_hw_client #(
    parameter int                     N_DATA_BITS   = 38,
    parameter int                     N_ADDR_BITS   = 14,
    parameter int                     TOTAL_LATENCY = 2,
    parameter int                     RSP_DEPTH     = 4,
    parameter logic [N_ADDR_BITS-1:0] ADDR_LIMIT    = {N_ADDR_BITS{1'b1}}
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    nx_ram_1rw_hw_client_if.slave bus
);

    localparam int                    c_PTR_BITS = $clog2(RSP_DEPTH);
    localparam int                    c_CNT_BITS = c_PTR_BITS + 1;
    localparam logic [c_CNT_BITS-1:0] c_DEPTH    = c_CNT_BITS'(RSP_DEPTH);
    localparam logic [c_CNT_BITS-1:0] c_ONE      = c_CNT_BITS'(1);

    logic                     w_ready;
    logic                     w_accept;
    logic                     w_rd_accept;
    logic                     w_addr_bad;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [N_DATA_BITS-1:0]   w_push_dat;

    logic [c_CNT_BITS-1:0]    credit_q;
    logic [c_CNT_BITS-1:0]    credit_d;
    logic [TOTAL_LATENCY-1:0] pipe_q;
    logic [TOTAL_LATENCY-1:0] pipe_d;
    logic [c_CNT_BITS-1:0]    wptr_q;
    logic [c_CNT_BITS-1:0]    wptr_d;
    logic [c_CNT_BITS-1:0]    rptr_q;
    logic [c_CNT_BITS-1:0]    rptr_d;
    logic [N_DATA_BITS-1:0]   fifo_q [RSP_DEPTH];

    // ------------------------------------------------------------------
    // Request acceptance and wrapper drive
    // ------------------------------------------------------------------
    // rst_n gates ready directly so nothing is accepted while reset is held.
    assign w_ready     = rst_n & ~bus.hw_yield & (bus.req_we | (credit_q != '0));
    assign w_accept    = bus.req_valid & w_ready;
    assign w_rd_accept = w_accept & ~bus.req_we;

    assign bus.req_ready = w_ready;
    assign bus.hw_cs     = w_accept & ~w_addr_bad;
    assign bus.hw_we     = bus.req_we;
    assign bus.hw_add    = bus.req_addr;
    assign bus.hw_bwe    = bus.req_bwe;
    assign bus.hw_din    = bus.req_wdat;

    // ------------------------------------------------------------------
    // Read-valid pipe matching the wrapper read latency
    // ------------------------------------------------------------------
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = w_rd_accept;
        for (int i = 1; i < TOTAL_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign w_push = pipe_q[TOTAL_LATENCY-1];

    // ------------------------------------------------------------------
    // Credits: one per FIFO slot not yet claimed by a stored or in-flight read
    // ------------------------------------------------------------------
    always_comb begin
        credit_d = credit_q;
        if (w_rd_accept && !w_pop) begin
            credit_d = credit_q - c_ONE;
        end else if (!w_rd_accept && w_pop) begin
            credit_d = credit_q + c_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[c_PTR_BITS] != rptr_q[c_PTR_BITS]) &&
                     (wptr_q[c_PTR_BITS-1:0] == rptr_q[c_PTR_BITS-1:0]);
    assign w_pop   = ~w_empty & bus.rsp_ready;

    assign wptr_d = w_push ? (wptr_q + c_ONE) : wptr_q;
    assign rptr_d = w_pop  ? (rptr_q + c_ONE) : rptr_q;

    assign bus.rsp_valid = ~w_empty;
    assign bus.rsp_dat   = fifo_q[rptr_q[c_PTR_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wptr_q[c_PTR_BITS-1:0]] <= w_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= c_DEPTH;
            pipe_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            credit_q <= credit_d;
            pipe_q   <= pipe_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional out-of-range address trap
    // ------------------------------------------------------------------
`ifdef NX_HW_CLIENT_ADDR_CHECK_EN
    logic [TOTAL_LATENCY-1:0] bad_q;
    logic [TOTAL_LATENCY-1:0] bad_d;
    logic                     addr_err_q;
    logic                     addr_err_d;

    assign w_addr_bad = (bus.req_addr > ADDR_LIMIT);

    // Trapped reads still occupy a slot so response ordering and credits
    // stay identical to a real read; their data is forced to zero.
    always_comb begin
        bad_d      = bad_q;
        bad_d[0]   = w_rd_accept & w_addr_bad;
        for (int i = 1; i < TOTAL_LATENCY; i++) begin
            bad_d[i] = bad_q[i-1];
        end
        addr_err_d = addr_err_q | (w_accept & w_addr_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            bad_q      <= bad_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign w_push_dat   = bad_q[TOTAL_LATENCY-1] ? '0 : bus.hw_dout;
    assign bus.addr_err = addr_err_q;
`else
    logic w_unused_addr_limit;

    assign w_addr_bad          = 1'b0;
    assign w_unused_addr_limit = ^ADDR_LIMIT;
    assign w_push_dat          = bus.hw_dout;
    assign bus.addr_err        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    logic [c_CNT_BITS-1:0] w_fifo_count;
    assign w_fifo_count = wptr_q - rptr_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (w_push && w_full) |-> w_pop);

    a_credit_nonneg: assert property (@(posedge clk) disable iff (!rst_n)
        w_rd_accept |-> (credit_q != '0));

    a_credit_range: assert property (@(posedge clk) disable iff (!rst_n)
        credit_q <= c_DEPTH);

    a_credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(credit_q) + int'(w_fifo_count) + $countones(pipe_q)) == RSP_DEPTH);

    a_yield_no_cs: assert property (@(posedge clk) disable iff (!rst_n)
        bus.hw_yield |-> !bus.hw_cs);
`endif

endmodule
`default_nettype wire
